// File: rtl/stc_pkg.sv
// Shared widths, FSM state type and magnitude helper for the 2:4 sparse encoder.
package stc_pkg;

   localparam int STC_IN_W   = 512;  // dense beat width: 64 int8 values
   localparam int STC_GROUPS = 16;   // groups of four values per beat
   localparam int STC_GRP_W  = 32;   // bits per dense group
   localparam int STC_SLOT_W = 16;   // bits per compressed group (two int8)
   localparam int STC_CNT_W  = 16;   // lossy-group counter width
   localparam int STC_IDX_W  = 2;    // bits per kept-position index

   typedef enum logic [0:0] {
      HALF0 = 1'b0,   // waiting for beat 0 of a tile
      HALF1 = 1'b1    // beat 0 staged, waiting for beat 1
   } enc_state_e;

   // Magnitude of an int8 at 9 bits so that |-128| = 128 is representable
   function automatic logic [8:0] abs9(input logic [7:0] v);
      logic [8:0] ext;
      ext = {v[7], v};
      if (v[7]) begin
         abs9 = 9'd0 - ext;
      end else begin
         abs9 = ext;
      end
   endfunction

endpackage

// File: rtl/sp24_group_sel.sv
// sp24_group_sel: picks the two largest-magnitude int8 values of one group of
// four, lower position winning ties, and reports whether a nonzero was dropped.
module sp24_group_sel
   import stc_pkg::*;
(
   input  logic [STC_GRP_W-1:0]   grp,
   output logic [STC_SLOT_W-1:0]  slot,
   output logic [2*STC_IDX_W-1:0] idx,
   output logic                   lossy
);

   logic [8:0]           mag_s  [4];
   logic [2:0]           rank_s [4];
   logic [3:0]           keep_s;
   logic [STC_IDX_W-1:0] p0_s;
   logic [STC_IDX_W-1:0] p1_s;

   // Magnitudes of the four values
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         mag_s[i] = abs9(grp[8*i +: 8]);
      end
   end

   // Rank each position by how many others beat it; the two with rank < 2 are kept
   always_comb begin
      keep_s = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         rank_s[i] = 3'd0;
         for (int j = 0; j < 4; j++) begin
            rank_s[i] = rank_s[i] + {2'b00, ((j != i) &&
                        ((mag_s[j] > mag_s[i]) || ((mag_s[j] == mag_s[i]) && (j < i))))};
         end
         keep_s[i] = (rank_s[i] < 3'd2);
      end
   end

   // Convert the kept mask into ordered positions p0 < p1
   always_comb begin
      p0_s = 2'd0;
      p1_s = 2'd1;
      case (keep_s)
         4'b0011: begin p0_s = 2'd0; p1_s = 2'd1; end
         4'b0101: begin p0_s = 2'd0; p1_s = 2'd2; end
         4'b1001: begin p0_s = 2'd0; p1_s = 2'd3; end
         4'b0110: begin p0_s = 2'd1; p1_s = 2'd2; end
         4'b1010: begin p0_s = 2'd1; p1_s = 2'd3; end
         4'b1100: begin p0_s = 2'd2; p1_s = 2'd3; end
         default: begin p0_s = 2'd0; p1_s = 2'd1; end
      endcase
   end

   // A group is lossy when any dropped value is nonzero
   always_comb begin
      lossy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         lossy = lossy | (~keep_s[i] & (|grp[8*i +: 8]));
      end
   end

   assign slot = {grp[{p1_s, 3'b000} +: 8], grp[{p0_s, 3'b000} +: 8]};
   assign idx  = {p1_s, p0_s};

endmodule

// File: rtl/sparse_24_encoder.sv
// sparse_24_encoder: compresses two dense int8 beats (one tile) into a single
// 2:4 sparse word plus position indices for the sparse tensor core operand path.
module sparse_24_encoder
   import stc_pkg::*;
#(
   parameter int IN_W  = STC_IN_W,
   parameter int CNT_W = STC_CNT_W
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IN_W-1:0]   out_data,
   output logic [IN_W/4-1:0] out_idx,
   output logic              out_lossy,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  lossy_cnt
);

   localparam int NG     = IN_W / STC_GRP_W;
   localparam int HALF_W = NG * STC_SLOT_W;
   localparam int HIDX_W = NG * 2 * STC_IDX_W;
   localparam int NUM_W  = $clog2(NG + 1);

   logic [HALF_W-1:0] comp_data_s;
   logic [HIDX_W-1:0] comp_idx_s;
   logic [NG-1:0]     grp_lossy_s;
   logic              beat_lossy_s;
   logic [NUM_W-1:0]  lossy_num_s;
   logic              accept_s;
   logic [CNT_W:0]    cnt_sum_s;

   enc_state_e        state_r;
   logic [HALF_W-1:0] staged_data_r;
   logic [HIDX_W-1:0] staged_idx_r;
   logic              staged_lossy_r;
   logic              out_valid_r;
   logic [IN_W-1:0]   out_data_r;
   logic [IN_W/4-1:0] out_idx_r;
   logic              out_lossy_r;
   logic [CNT_W-1:0]  lossy_cnt_r;

   for (genvar g = 0; g < NG; g++) begin : g_sel
      sp24_group_sel u_sel (
         .grp   (in_data[STC_GRP_W*g +: STC_GRP_W]),
         .slot  (comp_data_s[STC_SLOT_W*g +: STC_SLOT_W]),
         .idx   (comp_idx_s[2*STC_IDX_W*g +: 2*STC_IDX_W]),
         .lossy (grp_lossy_s[g])
      );
   end

   assign in_ready     = ~out_valid_r | out_ready;
   assign accept_s     = in_valid & in_ready;
   assign beat_lossy_s = |grp_lossy_s;

   // Number of lossy groups in the incoming beat
   always_comb begin
      lossy_num_s = {NUM_W{1'b0}};
      for (int g = 0; g < NG; g++) begin
         lossy_num_s = lossy_num_s + {{(NUM_W-1){1'b0}}, grp_lossy_s[g]};
      end
   end

   // Counter sum one bit wider so overflow is visible for saturation
   always_comb begin
      cnt_sum_s = {1'b0, lossy_cnt_r} + {{(CNT_W+1-NUM_W){1'b0}}, lossy_num_s};
   end

   // Tile assembly FSM: stage beat 0, emit the compressed word on the closing beat
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r        <= HALF0;
         staged_data_r  <= {HALF_W{1'b0}};
         staged_idx_r   <= {HIDX_W{1'b0}};
         staged_lossy_r <= 1'b0;
         out_valid_r    <= 1'b0;
         out_data_r     <= {IN_W{1'b0}};
         out_idx_r      <= {(IN_W/4){1'b0}};
         out_lossy_r    <= 1'b0;
      end else begin
         // A drain empties the holding register unless a load below refills it
         if (out_ready) begin
            out_valid_r <= 1'b0;
         end
         if (accept_s) begin
            case (state_r)
               HALF0: begin
                  if (in_last) begin
                     out_data_r  <= {{HALF_W{1'b0}}, comp_data_s};
                     out_idx_r   <= {{HIDX_W{1'b0}}, comp_idx_s};
                     out_lossy_r <= beat_lossy_s;
                     out_valid_r <= 1'b1;
                     state_r     <= HALF0;
                  end else begin
                     staged_data_r  <= comp_data_s;
                     staged_idx_r   <= comp_idx_s;
                     staged_lossy_r <= beat_lossy_s;
                     state_r        <= HALF1;
                  end
               end
               HALF1: begin
                  out_data_r  <= {comp_data_s, staged_data_r};
                  out_idx_r   <= {comp_idx_s, staged_idx_r};
                  out_lossy_r <= beat_lossy_s | staged_lossy_r;
                  out_valid_r <= 1'b1;
                  state_r     <= HALF0;
               end
               default: begin
                  state_r <= HALF0;
               end
            endcase
         end
      end
   end

   // Saturating lossy-group counter; clear wins over increment
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lossy_cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_clr) begin
         lossy_cnt_r <= {CNT_W{1'b0}};
      end else if (accept_s) begin
         if (cnt_sum_s[CNT_W]) begin
            lossy_cnt_r <= {CNT_W{1'b1}};
         end else begin
            lossy_cnt_r <= cnt_sum_s[CNT_W-1:0];
         end
      end
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_idx   = out_idx_r;
   assign out_lossy = out_lossy_r;
   assign lossy_cnt = lossy_cnt_r;

endmodule

// File: tb/tb_sparse_24_encoder.sv
// Self-checking bench for sparse_24_encoder: hand-computed group vectors,
// directed multi-cycle sequences and a randomized run against a reference model.
module tb_sparse_24_encoder;

   logic         clk;
   logic         rstn;
   logic         in_valid;
   logic         in_ready;
   logic [511:0] in_data;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [511:0] out_data;
   logic [127:0] out_idx;
   logic         out_lossy;
   logic         cnt_clr;
   logic [15:0]  lossy_cnt;

   int n_pass  = 0;
   int n_total = 0;
   int model_cnt = 0;

   typedef struct {
      logic [31:0] grp;
      logic [15:0] slot;
      logic [3:0]  idx;
      logic        lossy;
   } vec_t;

   typedef struct {
      logic [511:0] d;
      logic [127:0] i;
      logic         l;
   } word_t;

   sparse_24_encoder #(.IN_W(512), .CNT_W(16)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_lossy (out_lossy),
      .cnt_clr   (cnt_clr),
      .lossy_cnt (lossy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference: pick the largest magnitude, then the largest among the rest
   function automatic void ref_group(input logic [31:0] g, output logic [15:0] slot,
                                     output logic [3:0] idx, output bit lossy);
      int m[4];
      int a, b, p0, p1;
      logic [7:0] byt;
      for (int i = 0; i < 4; i++) begin
         byt  = g[8*i +: 8];
         m[i] = byt[7] ? (256 - int'(byt)) : int'(byt);
      end
      a = 0;
      for (int i = 1; i < 4; i++) if (m[i] > m[a]) a = i;
      b = (a == 0) ? 1 : 0;
      for (int i = 0; i < 4; i++) if (i != a && m[i] > m[b]) b = i;
      p0 = (a < b) ? a : b;
      p1 = (a < b) ? b : a;
      slot  = {g[8*p1 +: 8], g[8*p0 +: 8]};
      idx   = {2'(p1), 2'(p0)};
      lossy = 0;
      for (int i = 0; i < 4; i++) if (i != a && i != b && g[8*i +: 8] != 8'h00) lossy = 1;
   endfunction

   function automatic void ref_beat(input logic [511:0] d, output logic [255:0] c,
                                    output logic [63:0] ix, output int n);
      logic [15:0] s;
      logic [3:0]  x;
      bit          l;
      n = 0; c = '0; ix = '0;
      for (int g = 0; g < 16; g++) begin
         ref_group(d[32*g +: 32], s, x, l);
         c[16*g +: 16] = s;
         ix[4*g +: 4]  = x;
         n += int'(l);
      end
   endfunction

   function automatic logic [7:0] rand_byte();
      case ($urandom_range(0, 7))
         0, 1:    return 8'h00;
         2:       return 8'h01;
         3:       return 8'h7F;
         4:       return 8'h80;
         5:       return 8'h81;
         6:       return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   // Present one beat and wait (bounded) for it to be accepted
   task automatic send_beat(input logic [511:0] d, input logic last);
      int n;
      in_valid = 1'b1; in_data = d; in_last = last;
      #1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (!in_ready) chk("send_timeout", 512'(in_ready), 512'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic pulse_clr();
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      model_cnt = 0;
      chk("cnt_clr", 512'(lossy_cnt), 512'd0);
   endtask

   vec_t         vecs[7];
   word_t        q[$];
   logic [511:0] ed, all01, d14, d_a, d_b;
   logic [127:0] ei;
   logic [255:0] c, st_c;
   logic [63:0]  ix, st_i;
   bit           st_l, beat1, hs_in, hs_out;
   int           n;

   initial begin
      vecs[0] = '{32'h00FD0005, 16'hFD05, 4'h8, 1'b0};
      vecs[1] = '{32'h01010101, 16'h0101, 4'h4, 1'b1};
      vecs[2] = '{32'h007F7F80, 16'h7F80, 4'h4, 1'b1};
      vecs[3] = '{32'h00000000, 16'h0000, 4'h4, 1'b0};
      vecs[4] = '{32'h80000000, 16'h8000, 4'hC, 1'b0};
      vecs[5] = '{32'hFF7F0102, 16'h7F02, 4'h8, 1'b1};
      vecs[6] = '{32'h81807F00, 16'h807F, 4'h9, 1'b1};

      rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      out_ready = 1'b0; cnt_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 512'(out_valid), 512'd0);
      chk("rst_in_ready",  512'(in_ready),  512'd1);
      chk("rst_out_data",  out_data,        512'd0);
      chk("rst_out_idx",   512'(out_idx),   512'd0);
      chk("rst_out_lossy", 512'(out_lossy), 512'd0);
      chk("rst_lossy_cnt", 512'(lossy_cnt), 512'd0);
      rstn = 1'b1;
      @(posedge clk); #1;

      // Table vectors: each replicated into all 16 groups of a single-beat tile
      out_ready = 1'b1;
      for (int v = 0; v < 7; v++) begin
         ed = '0; ei = '0; d_a = '0;
         for (int g = 0; g < 16; g++) begin
            d_a[32*g +: 32] = vecs[v].grp;
            ed[16*g +: 16]  = vecs[v].slot;
            ei[4*g +: 4]    = vecs[v].idx;
         end
         if (v == 0) chk("pre_valid", 512'(out_valid), 512'd0);
         send_beat(d_a, 1'b1);
         model_cnt += vecs[v].lossy ? 16 : 0;
         chk($sformatf("vec%0d_valid", v), 512'(out_valid), 512'd1);
         chk($sformatf("vec%0d_data", v),  out_data, ed);
         chk($sformatf("vec%0d_idx", v),   512'(out_idx), 512'(ei));
         chk($sformatf("vec%0d_lossy", v), 512'(out_lossy), 512'(vecs[v].lossy));
         chk($sformatf("vec%0d_cnt", v),   512'(lossy_cnt), 512'(model_cnt));
      end

      // Two-beat tile of all 0x01: 32 lossy groups
      @(posedge clk); #1;
      pulse_clr();
      all01 = {64{8'h01}};
      send_beat(all01, 1'b0);
      chk("half1_no_valid", 512'(out_valid), 512'd0);
      send_beat(all01, 1'b0);
      chk("two_valid", 512'(out_valid), 512'd1);
      chk("two_data",  out_data, all01);
      chk("two_idx",   512'(out_idx), 512'({32{4'h4}}));
      chk("two_lossy", 512'(out_lossy), 512'd1);
      chk("two_cnt",   512'(lossy_cnt), 512'd32);

      // Backpressure: word held for 5 cycles, then drain and load together
      d_a = {16{32'h00FD0005}};
      d_b = {16{32'h007F7F80}};
      send_beat(d_a, 1'b1);
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = d_b; in_last = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_in_ready", 512'(in_ready), 512'd0);
         chk("bp_valid",    512'(out_valid), 512'd1);
         chk("bp_data",     out_data, {256'd0, {16{16'hFD05}}});
         chk("bp_idx",      512'(out_idx), 512'({64'd0, {16{4'h8}}}));
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 512'(in_ready), 512'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      chk("bp_new_valid", 512'(out_valid), 512'd1);
      chk("bp_new_data",  out_data, {256'd0, {16{16'h7F80}}});
      chk("bp_new_lossy", 512'(out_lossy), 512'd1);
      @(posedge clk); #1;
      chk("drain_clears", 512'(out_valid), 512'd0);

      // Reset in the middle of a tile discards the staged half
      send_beat({16{32'hFF7F0102}}, 1'b0);
      rstn = 1'b0;
      #1;
      chk("mid_rst_valid", 512'(out_valid), 512'd0);
      chk("mid_rst_cnt",   512'(lossy_cnt), 512'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      model_cnt = 0;
      @(posedge clk); #1;
      send_beat(d_a, 1'b1);
      chk("post_rst_data", out_data, {256'd0, {16{16'hFD05}}});
      chk("post_rst_idx",  512'(out_idx), 512'({64'd0, {16{4'h8}}}));

      // Randomized traffic against the reference model
      @(posedge clk); #1;
      pulse_clr();
      q.delete();
      beat1 = 0; hs_in = 0; in_valid = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!in_valid || hs_in) begin
            in_valid = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < 64; b++) in_data[8*b +: 8] = rand_byte();
            in_last = ($urandom_range(0, 3) == 0);
         end
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         chk("rnd_in_ready",  512'(in_ready), 512'((q.size() == 0) || out_ready));
         chk("rnd_out_valid", 512'(out_valid), 512'(q.size() != 0));
         chk("rnd_cnt",       512'(lossy_cnt), 512'(model_cnt));
         if (q.size() != 0) begin
            chk("rnd_data",  out_data, q[0].d);
            chk("rnd_idx",   512'(out_idx), 512'(q[0].i));
            chk("rnd_lossy", 512'(out_lossy), 512'(q[0].l));
         end
         hs_in  = in_valid && ((q.size() == 0) || out_ready);
         hs_out = (q.size() != 0) && out_ready;
         @(posedge clk); #1;
         if (hs_out) void'(q.pop_front());
         if (hs_in) begin
            ref_beat(in_data, c, ix, n);
            model_cnt += n;
            if (!beat1) begin
               if (in_last) q.push_back('{{256'd0, c}, {64'd0, ix}, n != 0});
               else begin st_c = c; st_i = ix; st_l = (n != 0); beat1 = 1; end
            end else begin
               q.push_back('{{c, st_c}, {ix, st_i}, (n != 0) || st_l});
               beat1 = 0;
            end
         end
      end
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      chk("rnd_final_cnt", 512'(lossy_cnt), 512'(model_cnt));
      if (beat1) send_beat('0, 1'b0);
      @(posedge clk); #1;

      // Counter saturation and clear priority
      pulse_clr();
      d14 = {64'd0, {14{32'h01010101}}};
      in_valid = 1'b1; in_data = all01; in_last = 1'b1;
      repeat (4095) @(posedge clk);
      #1;
      chk("sat_fff0", 512'(lossy_cnt), 512'(16'hFFF0));
      in_data = d14;
      @(posedge clk); #1;
      chk("sat_fffe", 512'(lossy_cnt), 512'(16'hFFFE));
      in_data = all01;
      @(posedge clk); #1;
      chk("sat_ffff", 512'(lossy_cnt), 512'(16'hFFFF));
      @(posedge clk); #1;
      chk("sat_hold", 512'(lossy_cnt), 512'(16'hFFFF));
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      chk("clr_priority", 512'(lossy_cnt), 512'd0);
      cnt_clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sparse_24_encoder.md
SPARSE_24_ENCODER -- requirements
Module: sparse_24_encoder

Interface
REQ-001 SHALL have parameter IN_W, default 512, meaning dense input beat width; it holds 64 int8 values in 16 groups of 4.
REQ-002 SHALL have parameter CNT_W, default 16, meaning lossy-group counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a dense beat is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the encoder accepts a beat this cycle.
REQ-007 SHALL have port in_data, input, 512 bits: value k occupies bits [8k+7:8k], group g = values 4g..4g+3.
REQ-008 SHALL have port in_last, input, 1 bit: the beat closes the tile; if on beat 0, the upper half is padded.
REQ-009 SHALL have port out_valid, input... corrected: out_valid, output, 1 bit: a compressed word is held.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer (sparse tensor core operand path) takes the word.
REQ-011 SHALL have port out_data, output, 512 bits: 32 groups x 2 kept int8 values.
REQ-012 SHALL have port out_idx, output, 128 bits: 32 groups x two 2-bit positions, in the core's weight-index format.
REQ-013 SHALL have port out_lossy, output, 1 bit: at least one dropped value in out_data was nonzero.
REQ-014 SHALL have port cnt_clr, input, 1 bit: synchronous clear of lossy_cnt.
REQ-015 SHALL have port lossy_cnt, output, CNT_W bits: saturating count of lossy groups.

Function
REQ-016 Per group, SHALL keep the two values with the largest magnitude; |0x80| = 128, computed at 9-bit width; ties go to the lower position.
REQ-017 Kept positions p0 < p1; p0's value SHALL go to byte 0 and p1's to byte 1 of the group's 16-bit slot, p0 to idx bits [1:0] and p1 to idx bits [3:2].
REQ-018 A group SHALL be lossy when either dropped value is nonzero.
REQ-019 State machine SHALL have states HALF0 (await beat 0) and HALF1 (await beat 1); reset state is HALF0.
REQ-020 in_ready SHALL equal (!out_valid || out_ready) in both states, and SHALL not depend on in_valid.
REQ-021 Beat accepted in HALF0 without in_last: compressed groups 0..15 SHALL be held in a staging register along with their lossy flag, and the state SHALL move to HALF1.
REQ-022 Beat accepted in HALF1: out_data SHALL load {comp(beat), staged} and out_idx SHALL load {idx(beat), staged_idx}; out_valid SHALL be set the next cycle and the state SHALL return to HALF0.
REQ-023 Beat accepted in HALF0 with in_last: the output SHALL load with upper 256 data bits = 0 and upper 64 idx bits = 0; the state SHALL stay HALF0.
REQ-024 in_last in HALF1 SHALL carry no extra meaning.
REQ-025 Latency SHALL be 1 cycle from the closing beat handshake to out_valid.
REQ-026 out_valid SHALL clear on out_ready when no load occurs in the same cycle; with simultaneous drain and load, out_valid SHALL stay 1 and carry the new data.
REQ-027 out_lossy SHALL be the OR of the lossy flags of the 32 groups in the held word.
REQ-028 lossy_cnt SHALL add the number of lossy groups (0..16) in each accepted beat and SHALL saturate at 2^CNT_W-1; cnt_clr SHALL take priority over the increment in the same cycle.
REQ-029 Outputs SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-030 On rstn low, state SHALL become HALF0, and out_valid, out_data, out_idx, out_lossy, the staging register and lossy_cnt SHALL become 0; in_ready SHALL read 1.
REQ-031 Reset mid-tile SHALL discard the staged half; the first beat after reset is beat 0.

Structure
REQ-032 Widths (IN_W, group count 16 per beat, CNT_W, idx width 2) SHALL live in shared package stc_pkg.
REQ-033 Per-group selection SHALL be a combinational sub-module sp24_group_sel (32-bit in, 16-bit value, 4-bit idx, lossy); it SHALL be instantiated 16 times.

Verification
REQ-034 Group {0x00,0xFD,0x00,0x05} (positions 3..0) -> slot 16'hFD05, idx 4'h8, not lossy.
REQ-035 Group all 0x01 -> slot 16'h0101, idx 4'h4, lossy; 16 such groups in each of 2 beats -> lossy_cnt = 32, out_lossy = 1.
REQ-036 Group {0x00,0x7F,0x7F,0x80} -> keep positions 0,1: slot 16'h7F80, idx 4'h4, lossy.
REQ-037 Beat 0 with in_last=1 -> out_data[511:256] = 0, out_idx[127:64] = 0, out_valid 1 cycle later.
REQ-038 out_ready held 0 for 5 cycles with a word pending -> in_ready = 0, outputs stable; then out_ready=1 together with a HALF1 beat -> new word, out_valid stays 1.
REQ-039 lossy_cnt preloaded to 0xFFFE, then +16 -> 0xFFFF; cnt_clr with a lossy beat in the same cycle -> 0.
